sample_frame_collector: RTL and testbench

SAMPLE_FRAME_COLLECTOR -- requirements
Module: sample_frame_collector

---
 rtl/sample_frame_collector_if.sv | 34 +++
 rtl/sample_frame_collector.sv | 100 ++++++++++
 tb/tb_sample_frame_collector.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sample_frame_collector_if.sv
// ------------------------------------------------------------------------
//  sample_frame_collector_if
//  Groups the ADC input, frame read port and status signals of the collector.
//  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface sample_frame_collector_if #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 16
);
  localparam int ADDR_W = $clog2(FRAME_LEN);

  logic              i_sample_clk;
  logic [DATA_W-1:0] i_adc_data;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              i_frame_ack;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_frame_valid;
  logic              o_overflow;
  logic [7:0]        o_drop_cnt;

  modport slave (
    input  i_sample_clk, i_adc_data, i_rd_addr, i_frame_ack,
    output o_rd_data, o_frame_valid, o_overflow, o_drop_cnt
  );

  modport master (
    output i_sample_clk, i_adc_data, i_rd_addr, i_frame_ack,
    input  o_rd_data, o_frame_valid, o_overflow, o_drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/sample_frame_collector.sv
// ------------------------------------------------------------------------
//  sample_frame_collector
//  Ping/pong frame buffer: fills one bank from ADC ticks, presents the other.
//  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sample_frame_collector #(
  parameter int DATA_W    = 12,
  parameter int FRAME_LEN = 16
) (
  input  wire                      i_clk,
  input  wire                      i_rst,
  sample_frame_collector_if.slave  bus
);
  localparam int ADDR_W = $clog2(FRAME_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  logic [DATA_W-1:0] bank_q [0:1][0:FRAME_LEN-1];

  logic              s_q;
  logic [ADDR_W-1:0] wr_idx_q,   wr_idx_d;
  logic              wr_sel_q,   wr_sel_d;
  logic              valid_q,    valid_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0] rd_data_q,  rd_data_d;

  logic tick;
  logic frame_done;
  logic read_free;

  assign tick       = bus.i_sample_clk & ~s_q;
  assign frame_done = tick && (wr_idx_q == LAST_IDX);
  // The read bank can take the new frame if idle or released this very cycle.
  assign read_free  = ~valid_q | bus.i_frame_ack;

  always_comb begin
    wr_idx_d   = wr_idx_q;
    wr_sel_d   = wr_sel_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    drop_cnt_d = drop_cnt_q;
    rd_data_d  = bank_q[~wr_sel_q][bus.i_rd_addr];

    // Index wraps to 0 on completion, so a dropped frame refills from the start.
    if (tick) begin
      wr_idx_d = ADDR_W'(wr_idx_q + 1'b1);
    end

    if (frame_done) begin
      if (read_free) begin
        wr_sel_d = ~wr_sel_q;
        valid_d  = 1'b1;
      end else begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end else if (bus.i_frame_ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_q        <= 1'b0;
      wr_idx_q   <= '0;
      wr_sel_q   <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      rd_data_q  <= '0;
    end else begin
      s_q        <= bus.i_sample_clk;
      wr_idx_q   <= wr_idx_d;
      wr_sel_q   <= wr_sel_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Sample storage carries no reset; only the write bank is ever written.
  always_ff @(posedge i_clk) begin
    if (tick) begin
      bank_q[wr_sel_q][wr_idx_q] <= bus.i_adc_data;
    end
  end

  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_frame_valid = valid_q;
  assign bus.o_overflow    = overflow_q;
  assign bus.o_drop_cnt    = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_frame_collector.sv
// ------------------------------------------------------------------------
//  tb_sample_frame_collector
//  Directed bench for the ping/pong sample frame collector.
//  Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_sample_frame_collector;
  localparam int DATA_W    = 12;
  localparam int FRAME_LEN = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   ov_cnt;
  logic v_after;

  sample_frame_collector_if #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) bus ();

  sample_frame_collector #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One count per cycle the overflow pulse is high.
  always @(negedge clk) begin
    if (bus.o_overflow === 1'b1) ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample_clk period of 4 clk cycles; ack optionally coincides with the tick cycle.
  task automatic tick(input logic [DATA_W-1:0] d, input logic ack);
    @(posedge clk); #1;
    bus.i_adc_data   = d;
    bus.i_sample_clk = 1'b1;
    bus.i_frame_ack  = ack;
    @(posedge clk); #1;
    v_after          = bus.o_frame_valid;
    bus.i_frame_ack  = 1'b0;
    @(posedge clk); #1;
    bus.i_sample_clk = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) tick(DATA_W'(base + i), 1'b0);
  endtask

  task automatic read_frame(input string tag, input int base);
    for (int a = 0; a < FRAME_LEN; a++) begin
      @(posedge clk); #1;
      bus.i_rd_addr = 4'(a);
      @(posedge clk); #1;
      check(tag, 32'(bus.o_rd_data), 32'(base + a));
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1;
    bus.i_frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_ack = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    ov_cnt = 0;
    v_after = 1'b0;
    rst = 1'b1;
    bus.i_sample_clk = 1'b0;
    bus.i_adc_data   = '0;
    bus.i_rd_addr    = '0;
    bus.i_frame_ack  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",    32'(bus.o_frame_valid), 32'd0);
    check("rst_overflow", 32'(bus.o_overflow),    32'd0);
    check("rst_drop",     32'(bus.o_drop_cnt),    32'd0);
    check("rst_rd_data",  32'(bus.o_rd_data),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ack with nothing presented is ignored.
    pulse_ack();
    repeat (2) @(posedge clk);
    #1;
    check("idle_ack_valid", 32'(bus.o_frame_valid), 32'd0);
    check("idle_ack_drop",  32'(bus.o_drop_cnt),    32'd0);
    check("idle_ack_ov",    32'(ov_cnt),            32'd0);

    // Frame 1: ramp 0..15.
    feed(0, 15);
    check("f1_valid_pre", 32'(bus.o_frame_valid), 32'd0);
    tick(12'd15, 1'b0);
    check("f1_valid_edge", 32'(v_after), 32'd1);
    read_frame("f1_data", 0);
    check("f1_drop", 32'(bus.o_drop_cnt), 32'd0);

    // Release frame 1, fill frame 2 with 16..31.
    pulse_ack();
    #1;
    check("f1_ack_valid", 32'(bus.o_frame_valid), 32'd0);
    feed(16, 16);
    check("f2_valid", 32'(bus.o_frame_valid), 32'd1);
    read_frame("f2_data", 16);
    check("f2_drop", 32'(bus.o_drop_cnt), 32'd0);
    check("f2_ov",   32'(ov_cnt),         32'd0);

    // Two frames complete while frame 2 is still held: both dropped.
    feed(32, 16);
    check("drop1_ov",    32'(ov_cnt),            32'd1);
    check("drop1_cnt",   32'(bus.o_drop_cnt),    32'd1);
    feed(48, 16);
    check("drop2_ov",    32'(ov_cnt),            32'd2);
    check("drop2_cnt",   32'(bus.o_drop_cnt),    32'd2);
    check("drop2_valid", 32'(bus.o_frame_valid), 32'd1);
    read_frame("held_data", 16);

    // Ack coincides with the final tick: swap without a drop.
    feed(64, 15);
    tick(12'd79, 1'b1);
    check("sim_ack_edge",  32'(v_after),           32'd1);
    check("sim_ack_valid", 32'(bus.o_frame_valid), 32'd1);
    check("sim_ack_ov",    32'(ov_cnt),            32'd2);
    check("sim_ack_drop",  32'(bus.o_drop_cnt),    32'd2);
    read_frame("sim_ack_data", 64);

    // Reset mid-frame after 7 ticks, checked while reset is held.
    feed(200, 7);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_valid",    32'(bus.o_frame_valid), 32'd0);
    check("mid_rst_overflow", 32'(bus.o_overflow),    32'd0);
    check("mid_rst_drop",     32'(bus.o_drop_cnt),    32'd0);
    check("mid_rst_rd_data",  32'(bus.o_rd_data),     32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_hold_valid", 32'(bus.o_frame_valid), 32'd0);
    rst = 1'b0;

    feed(100, 15);
    check("post_rst_valid_pre", 32'(bus.o_frame_valid), 32'd0);
    tick(12'd115, 1'b0);
    check("post_rst_valid", 32'(v_after), 32'd1);
    read_frame("post_rst_data", 100);
    check("post_rst_drop", 32'(bus.o_drop_cnt), 32'd0);
    check("post_rst_ov",   32'(ov_cnt),         32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
